sfp_accum: RTL
==============

# sfp_accum

Multi-pass partial-sum accumulator with a ReLU output stage: the parametrised successor to the per-column SFP instances in the corelet. It takes column-wide psum vectors from the OFIFO read side, sums them across a configurable number of kernel passes into an on-block buffer of `depth` output positions, and then drains the finished results through a valid/ready port. Pass and position counting is handled on-block, so the top-level controller only issues `start`.

## Interface
- `col`, 8, number of psum lanes (one per MAC column)
- `psum_bw`, 16, signed width of each lane, input and output
- `depth`, 16, number of output positions held in the buffer
- `npass_bw`, 4, width of the pass-count configuration
- `clk` input 1: single clock, rising edge
- `reset` input 1: synchronous, active-low
- `start` input 1: pulse that latches the configuration and begins a job; honoured only in IDLE
- `cfg_npass` input npass_bw: number of passes to accumulate, 1..2^npass_bw-1
- `cfg_npos` input clog2(depth+1): number of positions per pass, 1..depth
- `cfg_relu` input 1: when 1, negative results drain as 0
- `in_valid` input 1: `in_data` holds a valid psum vector
- `in_ready` output 1: block accepts input (ACCUM only)
- `in_data` input col*psum_bw: lane i occupies bits [psum_bw*(i+1)-1 : psum_bw*i]
- `out_valid` output 1: `out_data` holds a finished position
- `out_ready` input 1: consumer accepts `out_data`
- `out_data` output col*psum_bw: finished position, same lane packing
- `busy` output 1: state is not IDLE
- `done` output 1: one-cycle pulse when the job completes
- `cfg_err` output 1: one-cycle pulse when `start` is rejected because of an illegal configuration

## Operation
- States: IDLE, ACCUM, DRAIN.
- **IDLE**
  - When `start` is 1 and the configuration is legal: latch `cfg_*`, clear `wr_ptr`, `pass_cnt` and `rd_ptr`, and move to ACCUM.
  - Illegal configuration: `cfg_npass`==0, `cfg_npos`==0, or `cfg_npos`>`depth`. The block stays in IDLE and pulses `cfg_err`.
- **ACCUM**
  - `in_ready`=1.
  - On each handshake (`in_valid` & `in_ready`):
    - In pass 0, `buf[wr_ptr]` is overwritten with `in_data`.
    - In later passes, `buf[wr_ptr]` becomes `buf[wr_ptr]` + `in_data` per lane, as a signed add saturated to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
  - `wr_ptr` increments on each handshake. When `wr_ptr` reaches npos-1 it wraps to 0 and `pass_cnt` increments.
  - The handshake with `pass_cnt`==npass-1 and `wr_ptr`==npos-1 moves the block to DRAIN.
- **DRAIN**
  - `in_ready`=0 and `out_valid`=1.
  - `out_data` = `buf[rd_ptr]`, per lane forced to 0 if `cfg_relu` is set and the lane is negative.
  - Each handshake (`out_valid` & `out_ready`) increments `rd_ptr`.
  - The handshake at `rd_ptr`==npos-1 moves the block to IDLE and pulses `done` on the following cycle.
- `start` in ACCUM or DRAIN is ignored. It does not pulse `cfg_err`.
- Buffer contents are not cleared by reset, because pass 0 overwrites them. No output may expose stale contents outside DRAIN.
- Lanes are independent. Saturation in one lane does not affect any other lane.

## Timing
- Values while `reset`=0 and on the first cycle after release: state IDLE, `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `cfg_err`=0, and all counters 0.
- Reset asserted mid-job (ACCUM or DRAIN): the job is abandoned and the block returns to IDLE with the outputs above. No `done` pulse is issued.
- Start latency: with `start` sampled at edge t, `busy`=1 and `in_ready`=1 during cycle t+1.
- The write is committed at the same edge as the input handshake. There are no bubbles, so one input per cycle is sustainable.
- Accumulate to drain: after the final input handshake at edge k, `out_valid`=1 with position 0 in cycle k+1.
- `out_data` is read combinationally from buffer registers. It must stay stable while `out_valid` & !`out_ready`.
- Drain throughput is one position per cycle when `out_ready` is held at 1. Job cycles with full throughput and no stalls = 1 + npass*npos + npos.
- `done` and `cfg_err` are registered, single-cycle pulses. `done` is high in the cycle in which `busy` first reads 0.
- Back-to-back jobs: `start` asserted in the same cycle as `done` is accepted.
- `in_valid` while not in ACCUM is ignored, and no state changes.

## Test plan
- **Basic single pass:** col=8, npass=1, npos=4, relu=0. Feed inputs with lane i = 10*p + i for positions p=0..3 -> drains exactly those four vectors in order, then `done` pulses once.
- **Multi-pass accumulation:** npass=3, npos=2. Every lane of every input = 5 -> both positions drain 15. Total job length is 1+6+2 = 9 cycles with `out_ready`=1.
- **Saturation and ReLU:**
  - Two passes of +20000 in lane 0 -> 32767.
  - Two passes of -20000 in lane 1 -> -32768 with relu=0, and 0 with relu=1.
  - Lane 2 (+7 per pass) drains 14, unaffected by the other lanes.
- **Backpressure:**
  - Random `in_valid` gaps and random `out_ready` drops -> results are identical to the no-stall run.
  - `out_data` stays stable during every stall.
  - `in_data` presented in IDLE or DRAIN is not consumed.
- **Config errors and ignored start:**
  - `start` with npos=0, npos=depth+1, or npass=0 -> `cfg_err` pulses, `busy` stays 0.
  - `start` issued mid-ACCUM -> no effect on counters.
- **Reset mid-job:**
  - `reset`=0 for one cycle in the middle of pass 1 -> IDLE with all outputs 0 and no `done`.
  - A new job after the reset (npass=1) -> drains only the new inputs.

Source files
------------

// File: rtl/sfp_accum.sv
`default_nettype none
// ============================================================================
//  Module   : sfp_accum
//  Purpose  : Multi-pass partial-sum accumulator with a ReLU output stage.
//             Column-wide psum vectors are summed across cfg_npass kernel
//             passes into a buffer of cfg_npos positions (saturating signed
//             add per lane). The finished positions are then drained through
//             a valid/ready port, with optional ReLU clamping.
//
//  Parameters
//    col       : number of psum lanes (one per MAC column)
//    psum_bw   : signed width of each lane, input and output
//    depth     : number of output positions held in the buffer
//    npass_bw  : width of the pass-count configuration
//
//  Ports
//    clk        in   single clock, rising edge
//    reset      in   synchronous, active-low
//    start      in   pulse: latch configuration and begin a job (IDLE only)
//    cfg_npass  in   passes to accumulate, 1..2^npass_bw-1
//    cfg_npos   in   positions per pass, 1..depth
//    cfg_relu   in   clamp negative results to 0 on drain
//    in_valid   in   in_data holds a psum vector
//    in_ready   out  block accepts input (ACCUM only)
//    in_data    in   col lanes, lane i at [psum_bw*(i+1)-1 : psum_bw*i]
//    out_valid  out  out_data holds a finished position (DRAIN only)
//    out_ready  in   consumer accepts out_data
//    out_data   out  finished position, same lane packing
//    busy       out  state is not IDLE
//    done       out  one-cycle pulse after the last drained position
//    cfg_err    out  one-cycle pulse when start is rejected
//
//  Revision : 1.0 - initial release
// ============================================================================

module sfp_accum #(
    parameter int col      = 8,
    parameter int psum_bw  = 16,
    parameter int depth    = 16,
    parameter int npass_bw = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [npass_bw-1:0]          cfg_npass,
    input  logic [$clog2(depth+1)-1:0]   cfg_npos,
    input  logic                         cfg_relu,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [col*psum_bw-1:0]       in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [col*psum_bw-1:0]       out_data,
    output logic                         busy,
    output logic                         done,
    output logic                         cfg_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_NPOS_W = $clog2(depth + 1);
    localparam int c_PTR_W  = (depth > 1) ? $clog2(depth) : 1;
    localparam int c_WORD_W = col * psum_bw;

    localparam logic [psum_bw-1:0] c_SAT_MAX = {1'b0, {(psum_bw-1){1'b1}}};
    localparam logic [psum_bw-1:0] c_SAT_MIN = {1'b1, {(psum_bw-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State and configuration registers
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [npass_bw-1:0]    r_pass_cnt;
    logic [npass_bw-1:0]    r_npass;
    logic [c_NPOS_W-1:0]    r_npos;
    logic                   r_relu;
    logic                   r_done;
    logic                   r_cfg_err;

    // Position buffer; one packed word per output position. Not reset:
    // pass 0 overwrites every position that a job later reads.
    logic [c_WORD_W-1:0]    r_mem [depth];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic                   w_cfg_ok;
    logic                   w_accum;
    logic                   w_draining;
    logic                   w_wr_en;
    logic                   w_wr_last;
    logic                   w_rd_last;
    logic                   w_pass_last;
    logic                   w_first_pass;
    logic [c_WORD_W-1:0]    w_old_word;
    logic [c_WORD_W-1:0]    w_rd_word;
    logic [c_WORD_W-1:0]    w_wr_data;

    assign w_cfg_ok     = (cfg_npass != '0) &&
                          (cfg_npos  != '0) &&
                          (cfg_npos  <= c_NPOS_W'(depth));

    assign w_accum      = (r_state == S_ACCUM);
    assign w_draining   = (r_state == S_DRAIN);

    assign w_wr_last    = (c_NPOS_W'(r_wr_ptr) == (r_npos - c_NPOS_W'(1)));
    assign w_rd_last    = (c_NPOS_W'(r_rd_ptr) == (r_npos - c_NPOS_W'(1)));
    assign w_pass_last  = (r_pass_cnt == (r_npass - npass_bw'(1)));
    assign w_first_pass = (r_pass_cnt == '0);

    // Gated by reset so an edge that resets the FSM never commits a write.
    assign w_wr_en      = reset && w_accum && in_valid;

    assign w_old_word   = r_mem[r_wr_ptr];
    assign w_rd_word    = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------------
    // Per-lane datapath: saturating accumulate on the write side and
    // ReLU / visibility gating on the read side. Lanes are fully independent.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < col; gi++) begin : g_lane
        logic [psum_bw-1:0] w_old;
        logic [psum_bw-1:0] w_in;
        logic [psum_bw:0]   w_sum;
        logic [psum_bw-1:0] w_acc;
        logic [psum_bw-1:0] w_rd;

        assign w_old = w_old_word[gi*psum_bw +: psum_bw];
        assign w_in  = in_data[gi*psum_bw +: psum_bw];
        assign w_rd  = w_rd_word[gi*psum_bw +: psum_bw];

        // One guard bit: overflow shows as the two top sum bits disagreeing,
        // and the guard bit then gives the true sign of the result.
        assign w_sum = {w_old[psum_bw-1], w_old} + {w_in[psum_bw-1], w_in};

        always_comb begin
            w_acc = w_sum[psum_bw-1:0];
            if (w_sum[psum_bw] != w_sum[psum_bw-1]) begin
                w_acc = w_sum[psum_bw] ? c_SAT_MIN : c_SAT_MAX;
            end
        end

        assign w_wr_data[gi*psum_bw +: psum_bw] = w_first_pass ? w_in : w_acc;

        // Outside DRAIN the port reads 0 so stale buffer contents never leak.
        assign out_data[gi*psum_bw +: psum_bw] =
            (w_draining && !(r_relu && w_rd[psum_bw-1])) ? w_rd : '0;
    end

    // ------------------------------------------------------------------------
    // Buffer write port: committed on the same edge as the input handshake.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pass_cnt <= '0;
            r_npass    <= '0;
            r_npos     <= '0;
            r_relu     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cfg_ok) begin
                            r_npass    <= cfg_npass;
                            r_npos     <= cfg_npos;
                            r_relu     <= cfg_relu;
                            r_wr_ptr   <= '0;
                            r_rd_ptr   <= '0;
                            r_pass_cnt <= '0;
                            r_state    <= S_ACCUM;
                        end else begin
                            r_cfg_err  <= 1'b1;
                        end
                    end
                end

                S_ACCUM: begin
                    if (in_valid) begin
                        if (w_wr_last) begin
                            r_wr_ptr   <= '0;
                            r_pass_cnt <= r_pass_cnt + npass_bw'(1);
                            if (w_pass_last) begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (out_ready) begin
                        if (w_rd_last) begin
                            r_rd_ptr <= '0;
                            r_done   <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (decoded directly from registered state)
    // ------------------------------------------------------------------------
    assign in_ready  = w_accum;
    assign out_valid = w_draining;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;

endmodule

`default_nettype wire
